// File: rtl/alu_arb_if.sv
// Bus bundle for alu_arb: two command requesters, the shared ALU lines, and the response channel.
// slave is the arbiter's view; master is the view of the surrounding clients and ALU.
interface alu_arb_if #(
    parameter int W   = 8,
    parameter int OPW = 3
);
    logic           r0_valid;
    logic           r0_ready;
    logic [OPW-1:0] r0_op;
    logic [W-1:0]   r0_a;
    logic [W-1:0]   r0_b;
    logic           r1_valid;
    logic           r1_ready;
    logic [OPW-1:0] r1_op;
    logic [W-1:0]   r1_a;
    logic [W-1:0]   r1_b;
    logic [OPW-1:0] alu_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic           alu_en;
    logic [W-1:0]   alu_f;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;
    logic           busy;

    modport slave (
        input  r0_valid, r0_op, r0_a, r0_b,
        input  r1_valid, r1_op, r1_a, r1_b,
        input  alu_f, rsp_ready,
        output r0_ready, r1_ready,
        output alu_op, alu_a, alu_b, alu_en,
        output rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    modport master (
        output r0_valid, r0_op, r0_a, r0_b,
        output r1_valid, r1_op, r1_a, r1_b,
        output alu_f, rsp_ready,
        input  r0_ready, r1_ready,
        input  alu_op, alu_a, alu_b, alu_en,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/alu_arb.sv
// Round-robin sequencer sharing one combinational ALU between two requesters (IDLE -> ISSUE -> RESP).
// Optional macro ALU_ARB_DIVZ_EN: divide-by-zero commands skip the ALU and return all-ones with rsp_err set.
module alu_arb #(
    parameter int W   = 8,
    parameter int OPW = 3
) (
    input  logic     clk,
    input  logic     rst,
    alu_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t         state_q;
    logic           last_q;
    logic [OPW-1:0] alu_op_q;
    logic [W-1:0]   alu_a_q;
    logic [W-1:0]   alu_b_q;
    logic           alu_en_q;
    logic           rsp_valid_q;
    logic           rsp_id_q;
    logic [W-1:0]   rsp_data_q;
    logic           rsp_err_q;
    logic           busy_q;
    logic           divz_q;

    logic           gnt0;
    logic           gnt1;
    logic [OPW-1:0] sel_op;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic           sel_divz;

    // On a tie the requester that was not served last wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE) begin
            gnt0 = bus.r0_valid && (!bus.r1_valid || last_q);
            gnt1 = bus.r1_valid && (!bus.r0_valid || !last_q);
        end
    end

    assign sel_op = gnt1 ? bus.r1_op : bus.r0_op;
    assign sel_a  = gnt1 ? bus.r1_a  : bus.r0_a;
    assign sel_b  = gnt1 ? bus.r1_b  : bus.r0_b;

`ifdef ALU_ARB_DIVZ_EN
    assign sel_divz = (sel_op == OPW'(3)) && (sel_b == '0);
`else
    assign sel_divz = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_en_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            divz_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt0 || gnt1) begin
                        alu_op_q <= sel_op;
                        alu_a_q  <= sel_a;
                        alu_b_q  <= sel_b;
                        rsp_id_q <= gnt1;
                        divz_q   <= sel_divz;
                        alu_en_q <= !sel_divz;
                        busy_q   <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    alu_en_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= divz_q ? {W{1'b1}} : bus.alu_f;
                    rsp_err_q   <= divz_q;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        last_q      <= rsp_id_q;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.r0_ready  = gnt0;
    assign bus.r1_ready  = gnt1;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_en    = alu_en_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb: behavioural ALU, response scoreboard, and directed handshake scenarios.
module tb_alu_arb;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rsp_cnt = 0;
    logic [9:0] sb[$];

    alu_arb_if #(.W(8), .OPW(3)) bus ();

    alu_arb #(.W(8), .OPW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a * b;
            3'd3: r = (b == 8'h00) ? 8'hFF : a / b;
            3'd4: r = a >> 2;
            3'd5: r = b << 1;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // {id, err, data} the bench expects for a command taken from requester id.
    function automatic logic [9:0] exp_rsp(input logic id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
`ifdef ALU_ARB_DIVZ_EN
        if (op == 3'd3 && b == 8'h00) return {id, 1'b1, 8'hFF};
`endif
        return {id, 1'b0, alu_fn(op, a, b)};
    endfunction

    always_comb bus.alu_f = bus.alu_en ? alu_fn(bus.alu_op, bus.alu_a, bus.alu_b) : 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard and per-cycle protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.r0_valid && bus.r0_ready) sb.push_back(exp_rsp(1'b0, bus.r0_op, bus.r0_a, bus.r0_b));
            if (bus.r1_valid && bus.r1_ready) sb.push_back(exp_rsp(1'b1, bus.r1_op, bus.r1_a, bus.r1_b));
            check_eq("ready_onehot", {31'd0, bus.r0_ready & bus.r1_ready}, 0);
            check_eq("ready_while_busy", {31'd0, (bus.r0_ready | bus.r1_ready) & bus.busy}, 0);
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_cnt++;
                $display("[TB] rsp #%0d id=%0d data=%02h err=%0d", rsp_cnt, bus.rsp_id, bus.rsp_data, bus.rsp_err);
                if (sb.size() == 0) begin
                    check_eq("sb_unexpected_rsp", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check_eq("sb_id", {31'd0, bus.rsp_id}, {31'd0, e[9]});
                    check_eq("sb_err", {31'd0, bus.rsp_err}, {31'd0, e[8]});
                    check_eq("sb_data", {24'd0, bus.rsp_data}, {24'd0, e[7:0]});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while (bus.busy && t < 20) begin
            step();
            t++;
        end
        check_eq(tag, {31'd0, t < 20}, 1);
    endtask

    // Issue one command from requester id with rsp_ready held high; report ALU-enable cycles and the response.
    task automatic run_cmd(input logic id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           output int en_cycles, output logic [7:0] data, output logic err, output logic rid);
        int t = 0;
        bus.rsp_ready = 1'b1;
        if (id) begin
            bus.r1_valid = 1'b1; bus.r1_op = op; bus.r1_a = a; bus.r1_b = b;
        end else begin
            bus.r0_valid = 1'b1; bus.r0_op = op; bus.r0_a = a; bus.r0_b = b;
        end
        #1;
        while (!(id ? bus.r1_ready : bus.r0_ready) && t < 20) begin
            step();
            t++;
        end
        check_eq("grant_wait_bound", {31'd0, t < 20}, 1);
        step();
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        en_cycles = 0;
        t = 0;
        while (!bus.rsp_valid && t < 20) begin
            en_cycles += int'(bus.alu_en);
            step();
            t++;
        end
        check_eq("rsp_wait_bound", {31'd0, t < 20}, 1);
        data = bus.rsp_data;
        err  = bus.rsp_err;
        rid  = bus.rsp_id;
        step();
    endtask

    initial begin
        int         en_c;
        logic [7:0] d;
        logic       er;
        logic       ri;
        logic       exp_id;
        int         grants;

        rst = 1'b1;
        bus.r0_valid = 1'b0; bus.r0_op = '0; bus.r0_a = '0; bus.r0_b = '0;
        bus.r1_valid = 1'b0; bus.r1_op = '0; bus.r1_a = '0; bus.r1_b = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) step();
        check_eq("rst_alu_en", {31'd0, bus.alu_en}, 0);
        check_eq("rst_rsp_valid", {31'd0, bus.rsp_valid}, 0);
        check_eq("rst_busy", {31'd0, bus.busy}, 0);
        check_eq("rst_rsp_id", {31'd0, bus.rsp_id}, 0);
        check_eq("rst_rsp_data", {24'd0, bus.rsp_data}, 0);
        check_eq("rst_rsp_err", {31'd0, bus.rsp_err}, 0);
        check_eq("rst_alu_opab", {13'd0, bus.alu_op, bus.alu_a, bus.alu_b}, 0);
        rst = 1'b0;
        step();

        // Single add: exact cycle-by-cycle timing.
        $display("[TB] single add r0 05+03");
        bus.rsp_ready = 1'b1;
        bus.r0_valid = 1'b1; bus.r0_op = 3'd0; bus.r0_a = 8'h05; bus.r0_b = 8'h03;
        #1;
        check_eq("single_r0_ready", {31'd0, bus.r0_ready}, 1);
        check_eq("single_busy_T", {31'd0, bus.busy}, 0);
        step();
        bus.r0_valid = 1'b0;
        check_eq("single_en_T1", {31'd0, bus.alu_en}, 1);
        check_eq("single_busy_T1", {31'd0, bus.busy}, 1);
        check_eq("single_alu_a", {24'd0, bus.alu_a}, 32'h05);
        check_eq("single_rsp_valid_T1", {31'd0, bus.rsp_valid}, 0);
        step();
        check_eq("single_en_T2", {31'd0, bus.alu_en}, 0);
        check_eq("single_rsp_valid_T2", {31'd0, bus.rsp_valid}, 1);
        check_eq("single_rsp_id", {31'd0, bus.rsp_id}, 0);
        check_eq("single_rsp_data", {24'd0, bus.rsp_data}, 32'h08);
        check_eq("single_busy_T2", {31'd0, bus.busy}, 1);
        step();
        check_eq("single_rsp_valid_T3", {31'd0, bus.rsp_valid}, 0);
        check_eq("single_busy_T3", {31'd0, bus.busy}, 0);

        // Round-robin from a fresh pointer: both held valid, grants alternate starting with r0.
        $display("[TB] round-robin r0 sub / r1 shl");
        rst = 1'b1; step(); rst = 1'b0;
        bus.r0_valid = 1'b1; bus.r0_op = 3'd1; bus.r0_a = 8'h03; bus.r0_b = 8'h05;
        bus.r1_valid = 1'b1; bus.r1_op = 3'd5; bus.r1_a = 8'h00; bus.r1_b = 8'h81;
        exp_id = 1'b0;
        grants = 0;
        #1;
        for (int i = 0; i < 24; i++) begin
            if (bus.r0_ready || bus.r1_ready) begin
                check_eq("rr_grant_id", {31'd0, bus.r1_ready}, {31'd0, exp_id});
                exp_id = ~exp_id;
                grants++;
            end
            if (bus.rsp_valid) check_eq("rr_rsp_data", {24'd0, bus.rsp_data}, bus.rsp_id ? 32'h02 : 32'hFE);
            step();
        end
        check_eq("rr_grant_count", {31'd0, grants >= 6}, 1);
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        wait_idle("rr_idle_bound");

        // Backpressure: response must stay frozen and no grant happens.
        $display("[TB] backpressure r0 mul 10*10");
        bus.rsp_ready = 1'b0;
        bus.r0_valid = 1'b1; bus.r0_op = 3'd2; bus.r0_a = 8'h10; bus.r0_b = 8'h10;
        #1;
        check_eq("bp_r0_ready", {31'd0, bus.r0_ready}, 1);
        step();
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b1; bus.r1_op = 3'd0; bus.r1_a = 8'h01; bus.r1_b = 8'h01;
        step();
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_rsp_valid", {31'd0, bus.rsp_valid}, 1);
            check_eq("bp_rsp_data", {24'd0, bus.rsp_data}, 32'h00);
            check_eq("bp_rsp_id", {31'd0, bus.rsp_id}, 0);
            check_eq("bp_readies", {30'd0, bus.r1_ready, bus.r0_ready}, 0);
            step();
        end
        bus.r1_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        step();
        check_eq("bp_rsp_cleared", {31'd0, bus.rsp_valid}, 0);
        check_eq("bp_idle", {31'd0, bus.busy}, 0);

        // Reset during ISSUE aborts, then pointer is back to favouring r0.
        $display("[TB] reset during ISSUE");
        bus.r1_valid = 1'b1; bus.r1_op = 3'd0; bus.r1_a = 8'h11; bus.r1_b = 8'h22;
        #1;
        check_eq("rst_mid_r1_ready", {31'd0, bus.r1_ready}, 1);
        step();
        bus.r1_valid = 1'b0;
        check_eq("rst_mid_in_issue", {31'd0, bus.alu_en}, 1);
        rst = 1'b1;
        step();
        check_eq("rst_mid_alu_en", {31'd0, bus.alu_en}, 0);
        check_eq("rst_mid_rsp_valid", {31'd0, bus.rsp_valid}, 0);
        check_eq("rst_mid_busy", {31'd0, bus.busy}, 0);
        rst = 1'b0;
        bus.r0_valid = 1'b1; bus.r0_op = 3'd4; bus.r0_a = 8'h80; bus.r0_b = 8'h00;
        bus.r1_valid = 1'b1; bus.r1_op = 3'd0; bus.r1_a = 8'h01; bus.r1_b = 8'h02;
        #1;
        check_eq("rst_tie_r0_ready", {31'd0, bus.r0_ready}, 1);
        check_eq("rst_tie_r1_ready", {31'd0, bus.r1_ready}, 0);
        step();
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        wait_idle("rst_idle_bound");

        // Divide by zero and normal divide.
        $display("[TB] div 20/00");
        run_cmd(1'b1, 3'd3, 8'h20, 8'h00, en_c, d, er, ri);
`ifdef ALU_ARB_DIVZ_EN
        check_eq("divz_en_cycles", en_c, 0);
        check_eq("divz_data", {24'd0, d}, 32'hFF);
        check_eq("divz_err", {31'd0, er}, 1);
`else
        check_eq("divz_en_cycles", en_c, 1);
        check_eq("divz_err", {31'd0, er}, 0);
`endif
        check_eq("divz_id", {31'd0, ri}, 1);

        $display("[TB] div 20/04");
        run_cmd(1'b0, 3'd3, 8'h20, 8'h04, en_c, d, er, ri);
        check_eq("div_en_cycles", en_c, 1);
        check_eq("div_data", {24'd0, d}, 32'h08);
        check_eq("div_err", {31'd0, er}, 0);

        $display("[TB] shr 80>>2 and op 110");
        run_cmd(1'b1, 3'd4, 8'h80, 8'h00, en_c, d, er, ri);
        check_eq("shr_data", {24'd0, d}, 32'h20);
        run_cmd(1'b0, 3'd6, 8'h55, 8'h66, en_c, d, er, ri);
        check_eq("op6_data", {24'd0, d}, 32'h00);
        check_eq("op6_alu_op", {29'd0, bus.alu_op}, 32'd6);

        step();
        check_eq("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_arb.md
Name: alu_arb

Overview:
- Sequencer/arbiter that shares the single 8-bit combinational ALU (ops: add, sub, mul, div, a>>2, b<<1) between two requesters.
- Accepts one command at a time using a valid/ready handshake with round-robin priority.
- Drives the ALU operand/op/enable lines, captures the result, and returns it with the requester ID over a response handshake.
- Sits between the datapath clients and the ALU instance.

Parameters:
- W, 8, operand/result width; must match ALU width.
- OPW, 3, opcode width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- r0_valid  in  1  requester 0 command valid
- r0_ready  out  1  requester 0 command accepted this cycle
- r0_op  in  OPW  requester 0 opcode
- r0_a  in  W  requester 0 operand a
- r0_b  in  W  requester 0 operand b
- r1_valid, r1_ready, r1_op, r1_a, r1_b  same as r0_*, requester 1
- alu_op  out  OPW  opcode to ALU, registered
- alu_a  out  W  operand a to ALU, registered
- alu_b  out  W  operand b to ALU, registered
- alu_en  out  1  ALU output enable, registered
- alu_f  in  W  ALU result
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  1  requester that issued the command
- rsp_data  out  W  captured result
- rsp_err  out  1  error flag (see Optional Feature)
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values: FSM=IDLE; alu_op/alu_a/alu_b=0; alu_en=0; rsp_valid=0; rsp_id=0; rsp_data=0; rsp_err=0; rr pointer last=1, so r0 wins the first tie; busy=0.
- FSM states: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - Grant logic is combinational. If exactly one valid is high, grant it. If both are high, grant the requester != last.
  - rK_ready=1 only for the granted K, and only in IDLE.
  - On valid&ready, register op/a/b into alu_op/alu_a/alu_b and the id into rsp_id, then go to ISSUE.
  - With no valid, stay in IDLE; all ready signals are 0.
- ISSUE (1 cycle): alu_en=1. At the end of the cycle, capture alu_f into rsp_data, set rsp_valid=1, and go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id, rsp_data and rsp_err stable until rsp_ready=1.
  - On rsp_valid&rsp_ready, clear rsp_valid, set last=rsp_id, and go to IDLE.
  - No grants are made in this state.
- Latency: command accepted at cycle T -> alu_en high at T+1 -> rsp_valid high at T+2. Minimum issue interval is 3 cycles.
- alu_en is 0 in every state except ISSUE. alu_op/a/b hold their last values outside ISSUE.
- Arithmetic is owned by the ALU. The result is the low W bits: mul truncates, sub wraps. Opcodes 110/111 are forwarded unchanged, and the result is whatever the ALU returns (0).
- A requester dropping valid before ready carries no obligation. Commands are only taken on valid&ready.
- rst asserted in any state aborts the in-flight command with no response and returns all outputs and the pointer to their reset values on the next edge.

Optional Feature:
- Macro: ALU_ARB_DIVZ_EN.
- Defined: a command with op=3'b011 and b==0 is still sequenced through ISSUE, but alu_en stays 0 for that cycle. rsp_data={W{1'b1}} and rsp_err=1. The latency and handshake are otherwise identical.
- Undefined: no check is made. The ALU is enabled as for any op, rsp_data is whatever the ALU drives, and rsp_err is tied to 0.

Test Plan:
- Single command: r0 add a=8'h05 b=8'h03, rsp_ready=1 -> r0_ready at T, alu_en at T+1 only, rsp_valid at T+2 with rsp_id=0, rsp_data=8'h08, busy high T+1..T+2.
- Round-robin: r0 and r1 hold valid continuously with sub 8'h03-8'h05 and shl b=8'h81 -> grants alternate r0, r1, r0, ...; r0 responses are 8'hFE and r1 responses are 8'h02, with no grant while busy.
- Backpressure: mul 8'h10*8'h10 with rsp_ready=0 for 5 cycles -> rsp_data=8'h00 held stable, rsp_valid stays 1, both ready=0 throughout; response accepted on the first rsp_ready=1 cycle, then IDLE.
- Reset mid-op: rst pulsed during ISSUE -> next cycle alu_en=0, rsp_valid=0, busy=0; a following simultaneous request grants r0 first.
- Divide by zero: div a=8'h20 b=8'h00. With ALU_ARB_DIVZ_EN -> alu_en never high, rsp_data=8'hFF, rsp_err=1. Without it -> alu_en high one cycle, rsp_err=0.
- Divide normal: div 8'h20/8'h04 -> rsp_data=8'h08, rsp_err=0 in both builds.
